// File: rtl/encrypt_function_4.sv
// Function-4 encryptor: LFSR key seed R, 60-bit key expansion, add-mask, 78-bit frame.
// Optional `define ENC4_SEED_LOAD_EN adds seed_load/seed_val for reloading the LFSR.
module encrypt_function_4 #(
    parameter logic [10:0] LFSR_SEED = 11'h5A5,
    parameter logic [5:0]  FUNC_ID   = 6'd4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [59:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [77:0] outEnc,
`ifdef ENC4_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [10:0] seed_val,
`endif
    output logic [15:0] frame_cnt
);

    // An all-zero state would lock the LFSR, so zero seeds are forced to 1.
    function automatic logic [10:0] nonzero(input logic [10:0] v);
        return (v == 11'h000) ? 11'h001 : v;
    endfunction

    function automatic logic [59:0] expand_key(input logic [10:0] r);
        return {r, ~r, r, ~r, ~r, r[4:0]};
    endfunction

    localparam logic [10:0] SEED_SAFE = nonzero(LFSR_SEED);

    logic [10:0] lfsr;
    logic [10:0] lfsr_next;
    logic        accept;

    logic        s1_valid;
    logic [59:0] s1_data;
    logic [10:0] s1_r;
    logic [59:0] s1_b;

    logic        s2_valid;
    logic        s2_free;
    logic        s1_to_s2;
    logic [60:0] sum;

    assign s2_free  = !s2_valid || out_ready;
    assign s1_to_s2 = s1_valid && s2_free;
    // NOTE: in_ready depends combinationally on out_ready; there is no skid buffer.
    assign in_ready  = !s1_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign sum       = {1'b0, s1_data} + {1'b0, s1_b};

    always_comb begin
        lfsr_next = lfsr;
        if (accept)
            lfsr_next = {lfsr[9:0], lfsr[10] ^ lfsr[8]};
`ifdef ENC4_SEED_LOAD_EN
        // The accepted word already took the pre-load value as its R.
        if (seed_load)
            lfsr_next = nonzero(seed_val);
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            lfsr <= SEED_SAFE;
        else
            lfsr <= lfsr_next;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_r     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= data_in;
            s1_r     <= lfsr;
            s1_b     <= expand_key(lfsr);
        end else if (s1_to_s2) begin
            s1_valid <= 1'b0;
        end
    end

    // outEnc only loads on a transfer, so it keeps the last frame while out_valid is low.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s2_valid <= 1'b0;
            outEnc   <= '0;
        end else if (s1_to_s2) begin
            s2_valid <= 1'b1;
            outEnc   <= {s1_r, sum, FUNC_ID};
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            frame_cnt <= '0;
        else if (s2_valid && out_ready)
            frame_cnt <= frame_cnt + 16'd1;
    end

endmodule
